encryption_core: RTL



---
 rtl/encryption_core.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/encryption_core.sv
// encryption_core -- iterative AES-128 encryption engine.
//
// One forward AES round per clock (two per clock when ENC_UNROLL2_EN is
// defined). The round key is expanded on the fly from the previous round key,
// so no key schedule storage is needed. Both sides use valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   plain/key present
//   in_ready   core can accept a block (combinational from state and out_ready)
//   plain      128-bit plaintext, bits [127:120] = state byte s(0,0), column-major
//   key        128-bit cipher key, same byte order
//   out_valid  cipher valid (registered)
//   out_ready  consumer accepts cipher
//   cipher     128-bit ciphertext (registered)
//   busy       high while rounds are being computed (registered)
//
// Configuration macro:
//   ENC_UNROLL2_EN  two rounds per clock; latency 5 instead of 10.
module encryption_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef ENC_UNROLL2_EN
  localparam logic [3:0] STEP     = 4'd2;
  localparam logic [3:0] LAST_RND = 4'd9;
`else
  localparam logic [3:0] STEP     = 4'd1;
  localparam logic [3:0] LAST_RND = 4'd10;
`endif

  state_t       cur_state, next_state;
  logic [127:0] state_reg, rk_reg;
  logic [127:0] round_out, rk_out;
  logic [3:0]   rnd;
  logic         accept, last_round;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next round key: RotWord + SubWord + rcon on the last word, then xor chain.
  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sub_byte(w3[23:16]) ^ rc, sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One forward round; byte r+4c of the vector holds state element s(r,c).
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic skip_mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sub_byte(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r+4*c] = a[r+4*((c+r)%4)];
    if (!skip_mix) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c];
        c1 = b[4*c+1];
        c2 = b[4*c+2];
        c3 = b[4*c+3];
        b[4*c]   = xtime(c0) ^ xtime(c1) ^ c1 ^ c2 ^ c3;
        b[4*c+1] = c0 ^ xtime(c1) ^ xtime(c2) ^ c2 ^ c3;
        b[4*c+2] = c0 ^ c1 ^ xtime(c2) ^ xtime(c3) ^ c3;
        b[4*c+3] = xtime(c0) ^ c0 ^ c1 ^ c2 ^ xtime(c3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction

`ifdef ENC_UNROLL2_EN
  logic [127:0] rk_mid, state_mid;

  // Two chained rounds; rnd is always odd here, so only the second half
  // can be the final round that omits MixColumns.
  always_comb begin
    rk_mid    = expand_key(rk_reg, rcon_of(rnd));
    state_mid = enc_round(state_reg, rk_mid, 1'b0);
    rk_out    = expand_key(rk_mid, rcon_of(rnd + 4'd1));
    round_out = enc_round(state_mid, rk_out, rnd == 4'd9);
  end
`else
  always_comb begin
    rk_out    = expand_key(rk_reg, rcon_of(rnd));
    round_out = enc_round(state_reg, rk_out, rnd == 4'd10);
  end
`endif

  assign last_round = (rnd == LAST_RND);
  assign accept     = in_valid && in_ready;

  // In DONE the consumer's ready doubles as our ready so a new block can be
  // taken on the same edge the finished cipher is consumed.
  always_comb begin
    next_state = cur_state;
    in_ready   = 1'b0;
    case (cur_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_round) next_state = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) next_state = in_valid ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      state_reg <= '0;
      rk_reg    <= '0;
      rnd       <= '0;
      cipher    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (accept) begin
        state_reg <= plain ^ key;
        rk_reg    <= key;
        rnd       <= 4'd1;
        busy      <= 1'b1;
        out_valid <= 1'b0;
      end else if (cur_state == RUN) begin
        state_reg <= round_out;
        rk_reg    <= rk_out;
        if (last_round) begin
          cipher    <= round_out;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end else begin
          rnd <= rnd + STEP;
        end
      end else if (cur_state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
